// File: rtl/pe_pair_scheduler.sv
// Issue controller for the shared two-PE CORDIC pair: walks the fixed 8-op rotation
// schedule, sources PE inputs from the register file or PE feedback, and tags writebacks.
module pe_pair_scheduler #(
    parameter int PE_LATENCY = 8,
    parameter int NUM_OPS    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [1:0] pe0_valid,
    output logic [1:0] pe1_valid,
    output logic [1:0] pe0_scheme,
    output logic [1:0] pe1_scheme,
    output logic       src_sel,
    output logic       in_swap,
    output logic       rd_en,
    output logic       rd_rb,
    output logic       rd_cb,
    output logic       wb_en,
    output logic       wb_rb,
    output logic       wb_cb,
    output logic       wb_swap
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    typedef struct packed {
        logic valid;
        logic rb;
        logic cb;
        logic swap;
    } tag_t;

    typedef struct packed {
        logic [1:0] s0;
        logic [1:0] s1;
        logic       rb;
        logic       cb;
        logic       swap;
    } op_t;

    localparam logic [3:0] LAST = 4'(NUM_OPS);

    function automatic op_t op_at(input logic [2:0] i);
        op_t o;
        case (i)
            3'd0:    o = '{s0: 2'd0, s1: 2'd1, rb: 1'b0, cb: 1'b0, swap: 1'b0};
            3'd1:    o = '{s0: 2'd1, s1: 2'd1, rb: 1'b0, cb: 1'b1, swap: 1'b0};
            3'd2:    o = '{s0: 2'd0, s1: 2'd1, rb: 1'b1, cb: 1'b0, swap: 1'b0};
            3'd3:    o = '{s0: 2'd1, s1: 2'd1, rb: 1'b1, cb: 1'b1, swap: 1'b0};
            3'd4:    o = '{s0: 2'd2, s1: 2'd3, rb: 1'b0, cb: 1'b0, swap: 1'b0};
            3'd5:    o = '{s0: 2'd3, s1: 2'd3, rb: 1'b0, cb: 1'b1, swap: 1'b0};
            3'd6:    o = '{s0: 2'd2, s1: 2'd3, rb: 1'b1, cb: 1'b0, swap: 1'b1};
            default: o = '{s0: 2'd3, s1: 2'd3, rb: 1'b1, cb: 1'b1, swap: 1'b1};
        endcase
        return o;
    endfunction

    state_t                  state;
    logic [3:0]              ptr;
    logic [3:0]              pending;
    // Stage 0 is the issue cycle itself; stage PE_LATENCY is the writeback cycle.
    tag_t [PE_LATENCY:0]     tag_pipe;

    op_t        cur;
    logic [1:0] blk;
    tag_t       wb_nx;
    logic       wb_hit;
    logic       issue;
    logic       fb;
    logic       pipe_busy;
    logic [3:0] pending_nx;

    always_comb begin
        cur       = op_at(ptr[2:0]);
        blk       = {cur.rb, cur.cb};
        // Writeback that will be visible in the cycle being decided now.
        wb_nx     = tag_pipe[PE_LATENCY-1];
        wb_hit    = wb_nx.valid && ({wb_nx.rb, wb_nx.cb} == blk);
        fb        = pending[blk];
        issue     = (state == RUN) && (ptr < LAST) && (!pending[blk] || wb_hit);
        pipe_busy = 1'b0;
        for (int i = 0; i < PE_LATENCY; i++)
            pipe_busy = pipe_busy | tag_pipe[i].valid;
        pending_nx = pending;
        if (wb_nx.valid)
            pending_nx[{wb_nx.rb, wb_nx.cb}] = 1'b0;
        if (issue)
            pending_nx[blk] = 1'b1;
    end

    assign wb_en   = tag_pipe[PE_LATENCY].valid;
    assign wb_rb   = tag_pipe[PE_LATENCY].rb;
    assign wb_cb   = tag_pipe[PE_LATENCY].cb;
    assign wb_swap = tag_pipe[PE_LATENCY].swap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            pending    <= '0;
            tag_pipe   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pe0_valid  <= '0;
            pe1_valid  <= '0;
            pe0_scheme <= '0;
            pe1_scheme <= '0;
            src_sel    <= 1'b0;
            in_swap    <= 1'b0;
            rd_en      <= 1'b0;
            rd_rb      <= 1'b0;
            rd_cb      <= 1'b0;
        end else begin
            tag_pipe[0].valid <= issue;
            tag_pipe[0].rb    <= issue & cur.rb;
            tag_pipe[0].cb    <= issue & cur.cb;
            tag_pipe[0].swap  <= issue & cur.swap;
            for (int i = 1; i <= PE_LATENCY; i++)
                tag_pipe[i] <= tag_pipe[i-1];
            pending    <= pending_nx;

            pe0_valid  <= issue ? 2'b11 : 2'b00;
            pe1_valid  <= issue ? 2'b11 : 2'b00;
            pe0_scheme <= issue ? cur.s0 : 2'b00;
            pe1_scheme <= issue ? cur.s1 : 2'b00;
            in_swap    <= issue & cur.swap;
            src_sel    <= issue & fb;
            rd_en      <= issue & ~fb;
            rd_rb      <= issue & ~fb & cur.rb;
            rd_cb      <= issue & ~fb & cur.cb;

            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        ptr   <= '0;
                    end
                end
                RUN: begin
                    if (issue)
                        ptr <= ptr + 4'd1;
                    if (ptr == LAST && !pipe_busy) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        busy  <= 1'b1;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_pair_scheduler.sv
// Scoreboard bench: four schedulers (latency 8/4/6/2) run side by side; expected
// per-cycle output vectors are queued at stimulus time and popped by a monitor.
module tb_pe_pair_scheduler;
    localparam logic [3:0][3:0] LATS = {4'd2, 4'd6, 4'd4, 4'd8};

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [1:0] pe0v;
        logic [1:0] pe1v;
        logic [1:0] s0;
        logic [1:0] s1;
        logic       src;
        logic       isw;
        logic       rde;
        logic       rdrb;
        logic       rdcb;
        logic       wbe;
        logic       wbrb;
        logic       wbcb;
        logic       wbsw;
    } out_t;

    typedef struct packed {
        int   cyc;
        out_t v;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] start;
    logic [3:0] busy, done, src_sel, in_swap, rd_en, rd_rb, rd_cb, wb_en, wb_rb, wb_cb, wb_swap;
    logic [3:0][1:0] pe0_valid, pe1_valid, pe0_scheme, pe1_scheme;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t q [4][$];

    // Hand-derived issue timing per latency: op j issues in iss_c[d][j].
    int         iss_c  [4][8] = '{'{1,2,3,4,9,10,11,12}, '{1,2,3,4,5,6,7,8},
                                  '{1,2,3,4,7,8,9,10},   '{1,2,3,4,5,6,7,8}};
    logic [7:0] src_m  [4]    = '{8'hF0, 8'hF0, 8'hF0, 8'h00};
    int         done_c [4]    = '{21, 13, 17, 11};
    logic [1:0] sch0   [8]    = '{2'd0,2'd1,2'd0,2'd1,2'd2,2'd3,2'd2,2'd3};
    logic [1:0] sch1   [8]    = '{2'd1,2'd1,2'd1,2'd1,2'd3,2'd3,2'd3,2'd3};
    logic       op_rb  [8]    = '{0,0,1,1,0,0,1,1};
    logic       op_cb  [8]    = '{0,1,0,1,0,1,0,1};
    logic       op_sw  [8]    = '{0,0,0,0,0,0,1,1};

    for (genvar g = 0; g < 4; g++) begin : g_dut
        pe_pair_scheduler #(.PE_LATENCY(int'(LATS[g])), .NUM_OPS(8)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start[g]), .busy(busy[g]), .done(done[g]),
            .pe0_valid(pe0_valid[g]), .pe1_valid(pe1_valid[g]),
            .pe0_scheme(pe0_scheme[g]), .pe1_scheme(pe1_scheme[g]),
            .src_sel(src_sel[g]), .in_swap(in_swap[g]), .rd_en(rd_en[g]),
            .rd_rb(rd_rb[g]), .rd_cb(rd_cb[g]), .wb_en(wb_en[g]), .wb_rb(wb_rb[g]),
            .wb_cb(wb_cb[g]), .wb_swap(wb_swap[g])
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic out_t pk(input int d);
        out_t o;
        o = '{busy: busy[d], done: done[d], pe0v: pe0_valid[d], pe1v: pe1_valid[d],
              s0: pe0_scheme[d], s1: pe1_scheme[d], src: src_sel[d], isw: in_swap[d],
              rde: rd_en[d], rdrb: rd_rb[d], rdcb: rd_cb[d], wbe: wb_en[d],
              wbrb: wb_rb[d], wbcb: wb_cb[d], wbsw: wb_swap[d]};
        return o;
    endfunction

    // Any non-zero output is a DUT presentation and must match the queue head.
    always @(negedge clk) begin
        out_t a;
        exp_t e;
        for (int d = 0; d < 4; d++) begin
            a = pk(d);
            if (a != '0) begin
                checks++;
                if (q[d].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out dut%0d cyc %0d got %h expected nothing", d, cyc, a);
                end else begin
                    e = q[d].pop_front();
                    if (e.cyc != cyc || e.v != a) begin
                        errors++;
                        $display("FAIL out dut%0d cyc %0d got %h expected %h at cyc %0d",
                                 d, cyc, a, e.v, e.cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Queue expected vectors for a run whose start is sampled at absolute cycle base.
    task automatic push_run(input int base, input int cutoff);
        out_t ev [32];
        int   c, w, l;
        for (int d = 0; d < 4; d++) begin
            l = int'(LATS[d]);
            for (int k = 0; k < 32; k++) ev[k] = '0;
            for (int j = 0; j < 8; j++) begin
                c = iss_c[d][j];
                ev[c].pe0v = 2'b11;
                ev[c].pe1v = 2'b11;
                ev[c].s0   = sch0[j];
                ev[c].s1   = sch1[j];
                ev[c].isw  = op_sw[j];
                ev[c].src  = src_m[d][j];
                ev[c].rde  = ~src_m[d][j];
                ev[c].rdrb = ~src_m[d][j] & op_rb[j];
                ev[c].rdcb = ~src_m[d][j] & op_cb[j];
                w = c + l;
                ev[w].wbe  = 1'b1;
                ev[w].wbrb = op_rb[j];
                ev[w].wbcb = op_cb[j];
                ev[w].wbsw = op_sw[j];
            end
            for (int k = 1; k < done_c[d]; k++) ev[k].busy = 1'b1;
            ev[done_c[d]].done = 1'b1;
            for (int k = 0; k < 32 && k < cutoff; k++)
                if (ev[k] != '0) q[d].push_back('{cyc: base + k, v: ev[k]});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 4'h0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 4; d++) chk($sformatf("reset_zero_dut%0d", d), 32'(pk(d)), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single start pulse on all four latencies.
        push_run(cyc + 1, 32);
        start = 4'hF;
        @(negedge clk);
        start = 4'h0;
        repeat (26) @(negedge clk);

        // Start held through RUN and FIN: each DUT must run exactly once.
        push_run(cyc + 1, 32);
        for (int k = 0; k <= 22; k++) begin
            for (int d = 0; d < 4; d++) start[d] = (k <= done_c[d] + 1);
            @(negedge clk);
        end
        start = 4'h0;
        repeat (6) @(negedge clk);

        // Reset asserted during cycle 6: nothing from cycle 6 onward.
        push_run(cyc + 1, 6);
        start = 4'hF;
        @(negedge clk);
        start = 4'h0;
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 4; d++) chk($sformatf("midrun_reset_dut%0d", d), 32'(pk(d)), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Fresh start after reset repeats the first run's timing.
        push_run(cyc + 1, 32);
        start = 4'hF;
        @(negedge clk);
        start = 4'h0;
        repeat (26) @(negedge clk);

        for (int d = 0; d < 4; d++) chk($sformatf("queue_drained_dut%0d", d), 32'(q[d].size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
